// File: rtl/key_schedule_ctrl.sv
// rtl/key_schedule_ctrl.sv - AES-128 key expansion sequencer with round-key bank and read port

module key_schedule_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    // Entry 0 sits in the top byte, so the lookup offset is the inverted input.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout = SBOX_TABLE[{~din, 3'b000} +: 8];
endmodule

module key_schedule_ctrl #(
    parameter int NR = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [127:0]    key_in,
    output logic            busy,
    output logic            done,
    output logic            key_valid,
    output logic [1407:0]   expanded_key_out,
    input  logic [3:0]      rk_sel,
    output logic [127:0]    rk_out
);
    if (NR != 10) begin : g_nr_check
        $error("key_schedule_ctrl supports only NR = 10");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           round_q, round_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 key_valid_q, key_valid_d;
    logic [10:0][127:0]   bank_q, bank_d;
    logic [127:0]         cur_key_q, cur_key_d;
    logic [127:0]         rk_out_q, rk_out_d;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w, sub_w, t_w;
    logic [31:0] n0, n1, n2, n3;
    logic [127:0] next_key;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // cur_key_q always mirrors bank entry round-1, avoiding a wide read mux on the step input.
    assign w0 = cur_key_q[31:0];
    assign w1 = cur_key_q[63:32];
    assign w2 = cur_key_q[95:64];
    assign w3 = cur_key_q[127:96];

    assign rot_w = {w3[7:0], w3[31:8]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        key_schedule_sbox u_sbox (
            .din  (rot_w[8*i +: 8]),
            .dout (sub_w[8*i +: 8])
        );
    end

    assign t_w      = sub_w ^ {24'h000000, rcon(round_q)};
    assign n0       = t_w ^ w0;
    assign n1       = n0 ^ w1;
    assign n2       = n1 ^ w2;
    assign n3       = n2 ^ w3;
    assign next_key = {n3, n2, n1, n0};

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        key_valid_d = key_valid_q;
        bank_d      = bank_q;
        cur_key_d   = cur_key_q;

        rk_out_d = '0;
        for (int i = 0; i <= 10; i++) begin
            if (rk_sel == i[3:0]) begin
                rk_out_d = bank_q[i];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bank_d[0]   = key_in;
                    cur_key_d   = key_in;
                    round_d     = 4'd1;
                    key_valid_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_EXPAND;
                end
            end
            S_EXPAND: begin
                for (int i = 1; i <= 10; i++) begin
                    if (round_q == i[3:0]) begin
                        bank_d[i] = next_key;
                    end
                end
                cur_key_d = next_key;
                round_d   = round_q + 4'd1;
                if (round_q == 4'd10) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                done_d      = 1'b1;
                key_valid_d = 1'b1;
                busy_d      = 1'b0;
                round_d     = 4'd0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            round_q     <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_valid_q <= 1'b0;
            bank_q      <= '0;
            cur_key_q   <= '0;
            rk_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            key_valid_q <= key_valid_d;
            bank_q      <= bank_d;
            cur_key_q   <= cur_key_d;
            rk_out_q    <= rk_out_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign key_valid        = key_valid_q;
    assign expanded_key_out = bank_q;
    assign rk_out           = rk_out_q;
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb/tb_key_schedule_ctrl.sv - randomized self-checking bench for key_schedule_ctrl

module tb_key_schedule_ctrl;
    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [127:0]  key_in;
    logic          busy;
    logic          done;
    logic          key_valid;
    logic [1407:0] expanded_key_out;
    logic [3:0]    rk_sel;
    logic [127:0]  rk_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] sbox_tab [256];

    localparam logic [127:0] FIPS_KEY  = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
    localparam logic [127:0] FIPS_RK10 = 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0;
    localparam logic [127:0] ZERO_RK10 = 128'h8e188f6f_cf51e923_11e2923e_cb5befb4;

    key_schedule_ctrl #(.NR(10)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .key_in           (key_in),
        .busy             (busy),
        .done             (done),
        .key_valid        (key_valid),
        .expanded_key_out (expanded_key_out),
        .rk_sel           (rk_sel),
        .rk_out           (rk_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box derived from GF(2^8) inversion and the affine map, independent of any table.
    function automatic logic [7:0] sbox_calc(input logic [7:0] b);
        logic [7:0] inv = 8'h00;
        for (int x = 1; x < 256; x++) begin
            if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [1407:0] model_expand(input logic [127:0] key);
        logic [7:0] w [44][4];
        logic [7:0] t [4];
        logic [7:0] tmp;
        logic [7:0] rc = 8'h01;
        logic [1407:0] r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                w[i][j] = key[32*i + 8*j +: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
            if (i % 4 == 0) begin
                tmp  = t[0];
                t[0] = sbox_tab[t[1]] ^ rc;
                t[1] = sbox_tab[t[2]];
                t[2] = sbox_tab[t[3]];
                t[3] = sbox_tab[tmp];
                rc   = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
        end
        for (int i = 0; i < 44; i++)
            for (int j = 0; j < 4; j++)
                r[32*i + 8*j +: 8] = w[i][j];
        return r;
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launches one expansion and returns the cycle index (1 = cycle after accept) where done was seen.
    task automatic run_one(input logic [127:0] key, output int cyc);
        key_in = key;
        start  = 1'b1;
        step();
        start  = 1'b0;
        cyc    = 1;
        while (!done && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        key_in = '0;
        rk_sel = 4'd0;
        step();
        step();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_checks++;
        if (key_valid !== 1'b0) $display("FAIL reset_key_valid: got %b expected 0", key_valid); else n_pass++;
        n_checks++;
        if (expanded_key_out !== '0) $display("FAIL reset_bank: got nonzero %h expected 0", expanded_key_out[127:0]); else n_pass++;
        n_checks++;
        if (rk_out !== '0) $display("FAIL reset_rk_out: got %h expected 0", rk_out); else n_pass++;
        reset = 1'b0;
        step();
        step();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_fips_vector();
        int cyc;
        logic [1407:0] exp_bank;
        exp_bank = model_expand(FIPS_KEY);
        run_one(FIPS_KEY, cyc);
        n_checks++;
        if (cyc !== 12) $display("FAIL fips_done_latency: got %0d expected 12", cyc); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL fips_busy_at_done: got %b expected 0", busy); else n_pass++;
        n_checks++;
        if (key_valid !== 1'b1) $display("FAIL fips_key_valid: got %b expected 1", key_valid); else n_pass++;
        n_checks++;
        if (expanded_key_out[1407:1280] !== FIPS_RK10)
            $display("FAIL fips_rk10: got %h expected %h", expanded_key_out[1407:1280], FIPS_RK10);
        else n_pass++;
        n_checks++;
        if (expanded_key_out[159:128] !== 32'h17fefaa0)
            $display("FAIL fips_rk1_w0: got %h expected 17fefaa0", expanded_key_out[159:128]);
        else n_pass++;
        n_checks++;
        if (expanded_key_out !== exp_bank) $display("FAIL fips_schedule: got %h expected %h", expanded_key_out, exp_bank); else n_pass++;
        step();
        n_checks++;
        if (done !== 1'b0) $display("FAIL fips_done_pulse_width: got %b expected 0", done); else n_pass++;
    endtask

    task automatic test_read_port();
        logic [1407:0] exp_bank;
        logic [127:0]  exp_rk;
        int            sel;
        exp_bank = model_expand(FIPS_KEY);
        rk_sel = 4'd0;
        step();
        n_checks++;
        if (rk_out !== FIPS_KEY) $display("FAIL read_rk0: got %h expected %h", rk_out, FIPS_KEY); else n_pass++;
        rk_sel = 4'd10;
        step();
        n_checks++;
        if (rk_out !== FIPS_RK10) $display("FAIL read_rk10: got %h expected %h", rk_out, FIPS_RK10); else n_pass++;
        rk_sel = 4'd15;
        step();
        n_checks++;
        if (rk_out !== '0) $display("FAIL read_rk15: got %h expected 0", rk_out); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            sel    = $urandom_range(0, 15);
            rk_sel = 4'(sel);
            exp_rk = (sel <= 10) ? exp_bank[128*sel +: 128] : '0;
            step();
            n_checks++;
            if (rk_out !== exp_rk) $display("FAIL read_rand_sel%0d: got %h expected %h", sel, rk_out, exp_rk); else n_pass++;
        end
    endtask

    task automatic test_restart_ignored();
        logic [127:0]  key_a;
        logic [127:0]  key_b;
        logic [1407:0] exp_bank;
        int            n_done = 0;
        int            done_cyc = 0;
        key_a    = rand_key();
        key_b    = rand_key();
        exp_bank = model_expand(key_a);
        key_in = key_a;
        start  = 1'b1;
        step();
        start  = 1'b0;
        key_in = rand_key();
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (cyc == 5) begin
                start  = 1'b1;
                key_in = key_b;
            end else begin
                start = 1'b0;
            end
            if (cyc == 12) begin
                n_checks++;
                if (expanded_key_out !== exp_bank) $display("FAIL restart_schedule: got %h expected %h", expanded_key_out, exp_bank); else n_pass++;
            end
            step();
        end
        n_checks++;
        if (n_done !== 1) $display("FAIL restart_done_count: got %0d expected 1", n_done); else n_pass++;
        n_checks++;
        if (done_cyc !== 12) $display("FAIL restart_done_cycle: got %0d expected 12", done_cyc); else n_pass++;
        n_checks++;
        if (expanded_key_out !== exp_bank) $display("FAIL restart_bank_after: got %h expected %h", expanded_key_out, exp_bank); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [1407:0] exp_bank;
        key_in = rand_key();
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (busy !== 1'b1) $display("FAIL mid_busy_before_reset: got %b expected 1", busy); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++;
        if (key_valid !== 1'b0) $display("FAIL mid_reset_key_valid: got %b expected 0", key_valid); else n_pass++;
        n_checks++;
        if (expanded_key_out !== '0) $display("FAIL mid_reset_bank: got %h expected 0", expanded_key_out[767:0]); else n_pass++;
        n_checks++;
        if (rk_out !== '0) $display("FAIL mid_reset_rk_out: got %h expected 0", rk_out); else n_pass++;
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if (key_valid !== 1'b0) $display("FAIL mid_post_reset_key_valid: got %b expected 0", key_valid); else n_pass++;
        exp_bank = model_expand('0);
        run_one('0, cyc);
        n_checks++;
        if (cyc !== 12) $display("FAIL zero_done_latency: got %0d expected 12", cyc); else n_pass++;
        n_checks++;
        if (expanded_key_out[1407:1280] !== ZERO_RK10)
            $display("FAIL zero_rk10: got %h expected %h", expanded_key_out[1407:1280], ZERO_RK10);
        else n_pass++;
        n_checks++;
        if (expanded_key_out !== exp_bank) $display("FAIL zero_schedule: got %h expected %h", expanded_key_out, exp_bank); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] keys [3];
        logic         exp_flag;
        int           k = 0;
        for (int i = 0; i < 3; i++) keys[i] = rand_key();
        key_in = keys[0];
        start  = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            step();
            exp_flag = (c % 12 == 0);
            n_checks++;
            if (done !== exp_flag) $display("FAIL b2b_done_c%0d: got %b expected %b", c, done, exp_flag); else n_pass++;
            n_checks++;
            if (key_valid !== exp_flag) $display("FAIL b2b_key_valid_c%0d: got %b expected %b", c, key_valid, exp_flag); else n_pass++;
            if (exp_flag) begin
                n_checks++;
                if (expanded_key_out !== model_expand(keys[k]))
                    $display("FAIL b2b_schedule_run%0d: got %h expected %h", k, expanded_key_out, model_expand(keys[k]));
                else n_pass++;
                k++;
                if (k < 3) key_in = keys[k];
                else start = 1'b0;
            end
        end
        step();
    endtask

    task automatic test_random_keys();
        int            cyc;
        logic [127:0]  key;
        logic [1407:0] exp_bank;
        for (int i = 0; i < 4; i++) begin
            key      = rand_key();
            exp_bank = model_expand(key);
            run_one(key, cyc);
            n_checks++;
            if (cyc !== 12) $display("FAIL rand%0d_latency: got %0d expected 12", i, cyc); else n_pass++;
            n_checks++;
            if (expanded_key_out !== exp_bank) $display("FAIL rand%0d_schedule: got %h expected %h", i, expanded_key_out, exp_bank); else n_pass++;
            step();
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        key_in = '0;
        rk_sel = 4'd0;
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
        test_reset();
        test_fips_vector();
        test_read_port();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random_keys();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
Sequencing controller for AES-128 key expansion. It accepts a 128-bit cipher key through a start/busy/done handshake and runs one key-expansion round per clock, using a single shared round-step datapath. The round step is RotWord, SubWord, Rcon XOR and a 4-word XOR chain. It holds the 11 round keys in an internal register bank and exposes them two ways: as a flat 1408-bit bus, and through a registered indexed read port for the encrypt/decrypt round datapaths.

Parameters:
- NR, default 10: number of expansion rounds. Only 10 (AES-128) is supported; any other value is a compile-time error.

Ports:
- clk  in  1: clock, all state updates on rising edge.
- reset  in  1: asynchronous active-high reset.
- start  in  1: request expansion of key_in. Sampled only in IDLE.
- key_in  in  128: cipher key. Byte 0 is at [7:0]; word 0 is at [31:0].
- busy  out  1: high while an expansion is in progress.
- done  out  1: single-cycle pulse when all round keys are valid.
- key_valid  out  1: bank holds a complete schedule.
- expanded_key_out  out  1408: round key r at [128r+127:128r].
- rk_sel  in  4: round-key index for the read port.
- rk_out  out  128: registered round key selected by rk_sel.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE; round counter = 0.
  - busy = 0, done = 0, key_valid = 0.
  - Bank cleared, so expanded_key_out = 0 and rk_out = 0.
  - Asserting reset mid-expansion aborts it; no partial schedule is ever flagged valid.
- States: IDLE, EXPAND, FINISH.
- IDLE:
  - On an edge with start=1: store key_in as rk0, set round = 1, clear key_valid, set busy = 1, go to EXPAND.
  - If start=0, hold.
- EXPAND, per edge:
  - Compute rk[round] from rk[round-1] and store it; increment round.
  - When round = 10 is stored, go to FINISH.
- FINISH, one cycle:
  - done = 1, key_valid = 1, busy = 0.
  - Next edge returns to IDLE with done = 0.
- Round step (byte/word order as in the key_in port description):
  - t = w3 of the previous key, rotated so output bytes are (b1, b2, b3, b0), low byte first.
  - Apply S-box to each byte of t.
  - XOR t[7:0] with Rcon(round). Rcon for rounds 1..10 = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
  - n0 = t ^ w0, n1 = n0 ^ w1, n2 = n1 ^ w2, n3 = n2 ^ w3.
- Timing:
  - done is high during the 12th cycle after the start-accept edge.
  - Exactly 4 S-box instances are used, shared across all rounds.
- Handshake rules:
  - start while busy or in FINISH is ignored; the in-flight key is unaffected.
  - A new start after done overwrites the bank. key_valid drops on the accept edge and rises again at the next FINISH.
  - key_in is sampled only on the accept edge; later changes to key_in have no effect.
- Read port:
  - rk_out is updated every edge from rk_sel. Latency is 1 cycle.
  - rk_sel > 10 returns 0.
  - Reads during EXPAND return the bank contents as-is: already-computed keys are valid, others are stale or 0. Consumers must gate reads on key_valid.
- expanded_key_out is a direct view of the bank. It is stable whenever key_valid = 1.

Test Plan:
- Reset, then start with key_in = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b (FIPS-197 key 2b7e1516...):
  - done pulses exactly 12 cycles after the accept edge.
  - expanded_key_out[1407:1280] = 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0.
  - rk1 word0 = 32'h17fefaa0.
- After the case above:
  - rk_sel = 0 gives rk_out = key_in one cycle later.
  - rk_sel = 10 gives the round-10 value.
  - rk_sel = 15 gives 0.
- Pulse start again at cycle 5 of an expansion with a different key:
  - The result equals the first key's schedule.
  - No second done pulse occurs.
- Assert reset at EXPAND round 6:
  - busy, key_valid and the bank go to 0 immediately.
  - A following start with an all-zero key yields rk10 = FIPS all-zero-key vector b4ef5bcb3e92e21123e951cf6f8f188e (byte order reversed per word).
- Back-to-back starts:
  - start held high continuously gives expansions every 12 cycles.
  - key_valid is low from each accept edge until the next done.
